// File: rtl/fp16_pkg.sv
// Shared FP16 constants and sequencer state encoding.
// Optional bias feature: FP16_DOT_BIAS_EN (see fp16_dot_seq).
package fp16_pkg;

  localparam int          FP16_W    = 16;
  localparam logic [15:0] FP16_ZERO = 16'h0000;
  localparam logic [15:0] FP16_ONE  = 16'h3C00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

  typedef struct packed {
    logic [FP16_W-1:0] a;
    logic [FP16_W-1:0] b;
    logic [FP16_W-1:0] acc;
  } mac_op_t;

endpackage

// File: rtl/fp16_dot_lat_timer.sv
// Loadable down-counter that pulses done_o LAT cycles after load_i.
// Used to time one MAC pass inside fp16_dot_seq.
module fp16_dot_lat_timer #(
  parameter int LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  output logic done_o
);

  localparam int CW = (LAT < 1) ? 1 : $clog2(LAT + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          act_q, act_d;

  always_comb begin
    cnt_d = cnt_q;
    act_d = act_q;
    if (load_i) begin
      cnt_d = CW'(LAT);
      act_d = 1'b1;
    end else if (act_q) begin
      if (cnt_q == '0) begin
        act_d = 1'b0;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      act_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      act_q <= act_d;
    end
  end

  assign done_o = act_q && (cnt_q == '0);

endmodule

// File: rtl/fp16_dot_seq.sv
// FP16 dot-product sequencer driving an external pipelined MAC.
// `define FP16_DOT_BIAS_EN adds bias_in as the initial accumulator.
module fp16_dot_seq
  import fp16_pkg::*;
#(
  parameter int LEN_W       = 8,
  parameter int MAC_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
`ifdef FP16_DOT_BIAS_EN
  input  logic [FP16_W-1:0] bias_in,
`endif
  input  logic [FP16_W-1:0] in_a,
  input  logic [FP16_W-1:0] in_b,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [FP16_W-1:0] mac_a,
  output logic [FP16_W-1:0] mac_b,
  output logic [FP16_W-1:0] mac_acc,
  input  logic [FP16_W-1:0] mac_result,
  output logic [FP16_W-1:0] res_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              busy
);

  seq_state_e        state_q, state_d;
  mac_op_t           mac_q, mac_d;
  logic [FP16_W-1:0] acc_q, acc_d;
  logic [FP16_W-1:0] res_q, res_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [FP16_W-1:0] init_acc;
  logic              accept;
  logic              tmr_load;
  logic              tmr_done;

`ifdef FP16_DOT_BIAS_EN
  assign init_acc = bias_in;
`else
  assign init_acc = FP16_ZERO;
`endif

  assign accept   = in_valid && (state_q == ISSUE);
  assign tmr_load = accept;

  fp16_dot_lat_timer #(
    .LAT (MAC_LATENCY)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load_i (tmr_load),
    .done_o (tmr_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (len == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (accept) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (tmr_done) begin
          state_d = (rem_q == '0) ? DONE : ISSUE;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    res_valid = 1'b0;
    busy      = 1'b1;
    unique case (state_q)
      IDLE:    busy      = 1'b0;
      ISSUE:   in_ready  = 1'b1;
      WAIT:    busy      = 1'b1;
      DONE:    res_valid = 1'b1;
      default: busy      = 1'b0;
    endcase
  end

  // Datapath next-state; mac_* only change on an accepted pair.
  always_comb begin
    mac_d = mac_q;
    acc_d = acc_q;
    res_d = res_q;
    rem_d = rem_q;
    unique case (1'b1)
      (state_q == IDLE) && start: begin
        acc_d = init_acc;
        rem_d = len;
        if (len == '0) begin
          res_d = init_acc;
        end
      end
      accept: begin
        mac_d.a   = in_a;
        mac_d.b   = in_b;
        mac_d.acc = acc_q;
        rem_d     = rem_q - LEN_W'(1);
      end
      (state_q == WAIT) && tmr_done: begin
        acc_d = mac_result;
        if (rem_q == '0) begin
          res_d = mac_result;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mac_q <= '0;
      acc_q <= FP16_ZERO;
      res_q <= FP16_ZERO;
      rem_q <= '0;
    end else begin
      mac_q <= mac_d;
      acc_q <= acc_d;
      res_q <= res_d;
      rem_q <= rem_d;
    end
  end

  assign mac_a    = mac_q.a;
  assign mac_b    = mac_q.b;
  assign mac_acc  = mac_q.acc;
  assign res_data = res_q;

endmodule

// File: tb/tb_fp16_dot_seq.sv
// Scoreboard bench for fp16_dot_seq with a 2-stage FP16 MAC model.
// Bias checks are built when FP16_DOT_BIAS_EN is defined.
module tb_fp16_dot_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  len;
  logic [15:0] bias_in;
  logic [15:0] in_a, in_b;
  logic        in_valid, in_ready;
  logic [15:0] mac_a, mac_b, mac_acc, mac_result;
  logic [15:0] res_data;
  logic        res_valid, res_ready, busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic [15:0] exp_q[$];
  logic [15:0] opa[256];
  logic [15:0] opb[256];
  int acc_t[256];
  int rv_cyc, st_cyc;
  bit saw_ready;
  logic [15:0] tbl[9];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fp16_dot_seq #(.LEN_W(8), .MAC_LATENCY(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .len        (len),
`ifdef FP16_DOT_BIAS_EN
    .bias_in    (bias_in),
`endif
    .in_a       (in_a),
    .in_b       (in_b),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .mac_a      (mac_a),
    .mac_b      (mac_b),
    .mac_acc    (mac_acc),
    .mac_result (mac_result),
    .res_data   (res_data),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .busy       (busy)
  );

  function automatic real pow2(input int e);
    real r = 1.0;
    if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
    else for (int i = 0; i < -e; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real h2r(input logic [15:0] h);
    int  e = int'(h[14:10]);
    real r;
    if (e == 0) r = real'(h[9:0]) * pow2(-24);
    else r = (1.0 + real'(h[9:0]) / 1024.0) * pow2(e - 15);
    return h[15] ? -r : r;
  endfunction

  function automatic logic [15:0] r2h(input real x);
    real ax;
    int  e, m;
    logic [4:0] ef;
    logic [9:0] mf;
    if (x == 0.0) return 16'h0000;
    ax = (x < 0.0) ? -x : x;
    e = 15;
    while (ax >= 2.0) begin ax = ax / 2.0; e++; end
    while (ax < 1.0) begin ax = ax * 2.0; e--; end
    m = int'((ax - 1.0) * 1024.0);
    ef = e[4:0];
    mf = m[9:0];
    return {(x < 0.0), ef, mf};
  endfunction

  // External MAC: result appears two edges after operands.
  logic [15:0] p1 = 16'h0, p2 = 16'h0;
  always @(posedge clk) begin
    p1 <= r2h(h2r(mac_a) * h2r(mac_b) + h2r(mac_acc));
    p2 <= p1;
  end
  assign mac_result = p2;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_result: got %h expected none", res_data);
      end else begin
        chk("result", {16'h0, res_data}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic wait_accept(input int idx);
    bit a;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      a = in_ready;
      if (a) acc_t[idx] = cyc;
      @(posedge clk); #1;
      if (a) return;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL accept_timeout: got none expected in_ready");
  endtask

  task automatic do_op(input int n, input logic [15:0] bias,
                       input bit gaps, input int stall, input int mode);
    real sum;
    logic [15:0] ma0, hold;
    bit hs;
    rv_cyc = -1;
    saw_ready = 0;
`ifdef FP16_DOT_BIAS_EN
    sum = h2r(bias);
`else
    sum = 0.0;
`endif
    for (int i = 0; i < n; i++) sum = sum + h2r(opa[i]) * h2r(opb[i]);
    exp_q.push_back(r2h(sum));
    start = 1'b1;
    len = 8'(n);
    bias_in = bias;
    @(negedge clk);
    st_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    ma0 = mac_a;
    repeat (stall) begin
      @(negedge clk);
      chk("stall_ready", {31'h0, in_ready}, 32'h1);
      chk("stall_mac_a", {16'h0, mac_a}, {16'h0, ma0});
      @(posedge clk); #1;
    end
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin
        @(negedge clk); @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_a = opa[i];
      in_b = opb[i];
      wait_accept(i);
      in_valid = 1'b0;
    end
    if (mode == 2) begin
      res_ready = 1'b0;
      for (int k = 0; k < 200 && rv_cyc < 0; k++) begin
        @(negedge clk);
        if (res_valid) rv_cyc = cyc;
        else begin @(posedge clk); #1; end
      end
      hold = res_data;
      @(posedge clk); #1;
      repeat (6) begin
        start = 1'b1;
        len = 8'd5;
        @(negedge clk);
        chk("bp_valid", {31'h0, res_valid}, 32'h1);
        chk("bp_data", {16'h0, res_data}, {16'h0, hold});
        chk("bp_busy", {31'h0, busy}, 32'h1);
        @(posedge clk); #1;
      end
      start = 1'b0;
      res_ready = 1'b1;
      @(negedge clk); @(posedge clk); #1;
      @(negedge clk);
      chk("bp_idle_busy", {31'h0, busy}, 32'h0);
      chk("bp_idle_valid", {31'h0, res_valid}, 32'h0);
      @(posedge clk); #1;
      return;
    end
    for (int k = 0; k < 300; k++) begin
      res_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (in_ready) saw_ready = 1;
      if (res_valid && rv_cyc < 0) rv_cyc = cyc;
      hs = res_valid && res_ready;
      @(posedge clk); #1;
      if (hs) begin
        res_ready = 1'b1;
        return;
      end
    end
    res_ready = 1'b1;
    n_cmp++;
    n_bad++;
    $display("FAIL result_timeout: got none expected res_valid");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ma, mb, mc;
    tbl = '{16'hC000, 16'hBC00, 16'hB800, 16'h0000, 16'h3800,
            16'h3C00, 16'h3E00, 16'h4000, 16'h4200};
    rst = 1'b1; start = 1'b0; len = '0; bias_in = '0;
    in_a = '0; in_b = '0; in_valid = 1'b0; res_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {31'h0, in_ready}, 32'h0);
    chk("rst_res_valid", {31'h0, res_valid}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_mac", {mac_a, mac_b}, 32'h0);
    chk("rst_acc_res", {mac_acc, res_data}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 3; i++) begin
      opa[i] = 16'h3C00;
      opb[i] = 16'h4000;
    end
    do_op(3, 16'h0, 0, 0, 0);
    chk("basic_gap1", 32'(acc_t[1] - acc_t[0]), 32'd4);
    chk("basic_gap2", 32'(acc_t[2] - acc_t[1]), 32'd4);
    chk("basic_rv", 32'(rv_cyc - acc_t[2]), 32'd4);

    ma = mac_a; mb = mac_b; mc = mac_acc;
    do_op(0, 16'h0, 0, 0, 0);
    chk("zero_rv", 32'(rv_cyc - st_cyc), 32'd1);
    chk("zero_noready", {31'h0, saw_ready}, 32'h0);
    chk("zero_mac_ab", {mac_a, mac_b}, {ma, mb});
    chk("zero_mac_acc", {16'h0, mac_acc}, {16'h0, mc});

    opa[0] = 16'h4000; opb[0] = 16'h4200;
    opa[1] = 16'h3C00; opb[1] = 16'h3C00;
    do_op(2, 16'h0, 0, 5, 0);

    opa[0] = 16'h3C00; opb[0] = 16'h3C00;
    do_op(1, 16'h0, 0, 0, 2);

    start = 1'b1; len = 8'd3;
    @(negedge clk); @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b1; in_a = 16'h3C00; in_b = 16'h4000;
    wait_accept(0);
    wait_accept(1);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_flags", {29'h0, in_ready, res_valid, busy}, 32'h0);
    chk("mid_rst_mac", {mac_a, mac_b}, 32'h0);
    chk("mid_rst_acc_res", {mac_acc, res_data}, 32'h0);
    @(posedge clk); #1;
    opa[0] = 16'h3C00; opb[0] = 16'h3C00;
    do_op(1, 16'h0, 0, 0, 0);

`ifdef FP16_DOT_BIAS_EN
    opa[0] = 16'h3C00; opb[0] = 16'h3C00;
    do_op(1, 16'h3C00, 0, 0, 0);
    chk("bias_mac_acc", {16'h0, mac_acc}, 32'h3C00);
`endif

    for (int t = 0; t < 20; t++) begin
      int n = $urandom_range(0, 10);
      for (int i = 0; i < n; i++) begin
        opa[i] = tbl[$urandom_range(0, 8)];
        opb[i] = tbl[$urandom_range(0, 8)];
      end
      do_op(n, tbl[$urandom_range(0, 8)], 1, 0, 1);
    end

    repeat (4) @(posedge clk);
    #1;
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
